// File: rtl/lock_pkg.sv
// Shared constants and types for the dual-resource lock: default sizing,
// hold-counter width and the per-requester ownership/lockout states.
package lock_pkg;

   localparam int NREQ_DEF     = 4;
   localparam int MAX_HOLD_DEF = 16;
   localparam int HOLD_W       = $clog2(MAX_HOLD_DEF + 1);

   typedef enum logic [1:0] {
      LK_IDLE   = 2'd0,
      LK_OWNER  = 2'd1,
      LK_LOCKED = 2'd2
   } lock_state_e;

   function automatic int hold_width(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/hold_watchdog.sv
// Per-requester hold watchdog: counts cycles a requester owns anything,
// revokes at MAX_HOLD, pulses tmo and holds the requester in lockout.
module hold_watchdog
   import lock_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = HOLD_W
)
(
   input  logic clk,
   input  logic srst,
   input  logic keep,
   input  logic hold_next,
   input  logic req_any,
   output logic revoke,
   output logic tmo,
   output logic locked
);

   logic [CNT_W-1:0] cnt_reg;
   logic             tmo_reg;
   lock_state_e      state_reg;

   // cnt_reg counts the current cycle too, so a grant lives exactly MAX_HOLD
   // cycles; a requester releasing everything on this edge is never revoked.
   assign revoke = (cnt_reg == CNT_W'(MAX_HOLD)) && keep;
   assign tmo    = tmo_reg;
   assign locked = (state_reg == LK_LOCKED);

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg   <= '0;
         tmo_reg   <= 1'b0;
         state_reg <= LK_IDLE;
      end else begin
         tmo_reg <= revoke;
         cnt_reg <= hold_next ? cnt_reg + CNT_W'(1) : '0;
         case (state_reg)
            LK_IDLE:   if (hold_next) state_reg <= LK_OWNER;
            LK_OWNER: begin
               if (revoke)          state_reg <= LK_LOCKED;
               else if (!hold_next) state_reg <= LK_IDLE;
            end
            LK_LOCKED: if (!req_any) state_reg <= LK_IDLE;
            default:   state_reg <= LK_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dual_resource_lock.sv
// Two-resource lock for NREQ requesters: atomic all-or-nothing allocation
// from a rotating pointer, first-blocked reservation and hold watchdogs.
module dual_resource_lock
   import lock_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQA,
   input  logic [NREQ-1:0] REQB,
   output logic [NREQ-1:0] GNTA,
   output logic [NREQ-1:0] GNTB,
   output logic [NREQ-1:0] TMO,
   output logic            BUSYA,
   output logic            BUSYB
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = hold_width(MAX_HOLD);

   logic [NREQ-1:0]  gnta_reg, gntb_reg;
   logic [NREQ-1:0]  gnta_next, gntb_next;
   logic             busya_reg, busyb_reg;
   logic [PTR_W-1:0] ptr_reg, ptr_next;

   logic [NREQ-1:0]  keep_a, keep_b, kept_a, kept_b;
   logic [NREQ-1:0]  revoke, locked, tmo_vec, eligible;
   logic [NREQ-1:0]  new_a, new_b;

   logic             taken_a, taken_b, reserved, any_grant;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx, last_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign keep_a[gi]   = gnta_reg[gi] & REQA[gi];
         assign keep_b[gi]   = gntb_reg[gi] & REQB[gi];
         assign eligible[gi] = ~(gnta_reg[gi] | gntb_reg[gi]) & ~locked[gi]
                               & (REQA[gi] | REQB[gi]);

         hold_watchdog #(
            .MAX_HOLD (MAX_HOLD),
            .CNT_W    (CNT_W)
         ) u_wd (
            .clk       (CLK),
            .srst      (RST),
            .keep      (keep_a[gi] | keep_b[gi]),
            .hold_next (gnta_next[gi] | gntb_next[gi]),
            .req_any   (REQA[gi] | REQB[gi]),
            .revoke    (revoke[gi]),
            .tmo       (tmo_vec[gi]),
            .locked    (locked[gi])
         );
      end
   endgenerate

   // Revoked grants free their resource on the same edge, like a release.
   assign kept_a = keep_a & ~revoke;
   assign kept_b = keep_b & ~revoke;

   always_comb begin
      new_a     = '0;
      new_b     = '0;
      taken_a   = |kept_a;
      taken_b   = |kept_b;
      reserved  = 1'b0;
      any_grant = 1'b0;
      last_idx  = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
         idx = sum[PTR_W-1:0];
         if (eligible[idx]) begin
            if (!(REQA[idx] && taken_a) && !(REQB[idx] && taken_b)) begin
               new_a[idx] = REQA[idx];
               new_b[idx] = REQB[idx];
               taken_a    = taken_a | REQA[idx];
               taken_b    = taken_b | REQB[idx];
               any_grant  = 1'b1;
               last_idx   = idx;
            end else if (!reserved) begin
               // first blocked candidate keeps later ones off its resources
               reserved = 1'b1;
               taken_a  = taken_a | REQA[idx];
               taken_b  = taken_b | REQB[idx];
            end
         end
      end
   end

   assign gnta_next = kept_a | new_a;
   assign gntb_next = kept_b | new_b;

   always_comb begin
      ptr_next = ptr_reg;
      if (any_grant)
         ptr_next = (last_idx == PTR_W'(NREQ - 1)) ? '0 : last_idx + PTR_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         gnta_reg  <= '0;
         gntb_reg  <= '0;
         busya_reg <= 1'b0;
         busyb_reg <= 1'b0;
         ptr_reg   <= '0;
      end else begin
         gnta_reg  <= gnta_next;
         gntb_reg  <= gntb_next;
         busya_reg <= |gnta_next;
         busyb_reg <= |gntb_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign GNTA  = gnta_reg;
   assign GNTB  = gntb_reg;
   assign TMO   = tmo_vec;
   assign BUSYA = busya_reg;
   assign BUSYB = busyb_reg;

endmodule

// File: tb/tb_dual_resource_lock.sv
// Directed bench for dual_resource_lock (NREQ=4, MAX_HOLD=16): hand-computed
// grants, reservation, rotation, watchdog lockout and reset behaviour.
module tb_dual_resource_lock;

   logic       clk, rst;
   logic [3:0] reqa, reqb;
   logic [3:0] gnta, gntb, tmo;
   logic       busya, busyb;
   int         checks = 0;
   int         errors = 0;
   logic       inv_on = 1'b0;
   int         owner, nxt;

   dual_resource_lock #(.NREQ(4), .MAX_HOLD(16)) dut (
      .CLK   (clk),
      .RST   (rst),
      .REQA  (reqa),
      .REQB  (reqb),
      .GNTA  (gnta),
      .GNTB  (gntb),
      .TMO   (tmo),
      .BUSYA (busya),
      .BUSYB (busyb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (inv_on) begin
         checks++;
         assert ($onehot0(gnta) && $onehot0(gntb) && (busya == |gnta) && (busyb == |gntb))
         else begin
            errors++;
            $error("FAIL invariant gnta=%b gntb=%b busya=%b busyb=%b", gnta, gntb, busya, busyb);
         end
      end
   end

   initial begin
      rst = 1'b1; reqa = 4'b0000; reqb = 4'b0000;
      tick(2);
      check("rst_gnta", gnta, 0);
      check("rst_gntb", gntb, 0);
      check("rst_tmo", tmo, 0);
      check("rst_busya", busya, 0);
      check("rst_busyb", busyb, 0);
      rst = 1'b0; inv_on = 1'b1;
      tick();
      check("idle_gnta", gnta, 0);

      // single grant and release
      reqa = 4'b0001; tick();
      check("basic_gnta", gnta, 4'b0001);
      check("basic_busya", busya, 1);
      reqa = 4'b0000; tick();
      check("basic_rel", gnta, 0);
      check("basic_busya0", busya, 0);

      // move pointer to 2, then atomic pair grant and handoff
      reqa = 4'b0010; tick();
      check("ptr2_gnta", gnta, 4'b0010);
      reqa = 4'b0000; tick();
      reqa = 4'b0110; reqb = 4'b0100; tick();
      check("pair_gnta", gnta, 4'b0100);
      check("pair_gntb", gntb, 4'b0100);
      reqa = 4'b0010; tick();
      check("handoff_gnta", gnta, 4'b0010);
      check("handoff_gntb", gntb, 4'b0100);
      reqa = 4'b0000; reqb = 4'b0000; tick();
      check("pair_clr_a", gnta, 0);
      check("pair_clr_busyb", busyb, 0);

      // reservation: r0 holds A, r3 wants A+B at PTR=3, r1 wants B
      reqa = 4'b0001; tick();
      check("res_r0", gnta, 4'b0001);
      reqb = 4'b0100; tick();
      check("res_ptr3", gntb, 4'b0100);
      reqb = 4'b0000; tick();
      check("res_ptr3_clr", gntb, 0);
      reqa = 4'b1001; reqb = 4'b1010; tick();
      check("res_hold_a", gnta, 4'b0001);
      check("res_block_b", gntb, 4'b0000);
      tick();
      check("res_block_b2", gntb, 4'b0000);
      reqa = 4'b1000; tick();
      check("res_pair_a", gnta, 4'b1000);
      check("res_pair_b", gntb, 4'b1000);
      reqa = 4'b0000; reqb = 4'b0010; tick();
      check("res_rel_a", gnta, 0);
      check("res_r1_b", gntb, 4'b0010);
      reqb = 4'b0000; tick();
      check("res_clr_b", gntb, 0);

      // watchdog revocation and lockout on r2
      reqa = 4'b0100; tick();
      check("wd_grant", gnta, 4'b0100);
      tick(15);
      check("wd_last_hold", gnta, 4'b0100);
      check("wd_no_tmo_yet", tmo, 0);
      tick();
      check("wd_revoke", gnta, 0);
      check("wd_tmo", tmo, 4'b0100);
      check("wd_busya", busya, 0);
      tick();
      check("wd_tmo_pulse", tmo, 0);
      check("wd_locked_a", gnta, 0);
      reqa = 4'b0000; reqb = 4'b0100; tick(2);
      check("wd_locked_b", gntb, 0);
      reqa = 4'b0100; tick();
      check("wd_locked_ab", gnta, 0);
      reqa = 4'b0000; reqb = 4'b0000; tick();
      reqa = 4'b0100; tick();
      check("wd_unlocked", gnta, 4'b0100);
      reqa = 4'b0000; tick();
      check("wd_unlock_rel", gnta, 0);

      // release coinciding with revocation: no TMO, no lockout
      reqa = 4'b0010; tick();
      check("co_grant", gnta, 4'b0010);
      tick(15);
      check("co_hold", gnta, 4'b0010);
      reqa = 4'b0000; tick();
      check("co_rel", gnta, 0);
      check("co_no_tmo", tmo, 0);
      reqa = 4'b0010; tick();
      check("co_regrant", gnta, 4'b0010);
      reqa = 4'b0000; tick();
      check("co_clr", gnta, 0);

      // round-robin rotation with zero-bubble handoff
      reqa = 4'b1000; tick();
      check("rot_ptr0", gnta, 4'b1000);
      reqa = 4'b0000; tick();
      reqa = 4'b1111; tick();
      check("rot_first", gnta, 4'b0001);
      owner = 0;
      for (int s = 0; s < 4; s++) begin
         tick(2);
         check("rot_hold", gnta, 32'd1 << owner);
         reqa[owner] = 1'b0;
         tick();
         nxt = (owner + 1) % 4;
         check("rot_next", gnta, 32'd1 << nxt);
         check("rot_busya", busya, 1);
         reqa[owner] = 1'b1;
         owner = nxt;
      end

      // reset while both resources are granted
      reqa = 4'b0001; reqb = 4'b0010; tick();
      check("rstm_a", gnta, 4'b0001);
      check("rstm_b", gntb, 4'b0010);
      rst = 1'b1; tick();
      check("rstm_clr_a", gnta, 0);
      check("rstm_clr_b", gntb, 0);
      check("rstm_busya", busya, 0);
      check("rstm_busyb", busyb, 0);
      check("rstm_tmo", tmo, 0);
      rst = 1'b0; tick();
      check("rstm_resume_a", gnta, 4'b0001);
      check("rstm_resume_b", gntb, 4'b0010);
      reqa = 4'b0000; reqb = 4'b0000; tick();
      check("end_clr", gnta, 0);

      inv_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
